exe_stage_md: RTL and testbench
===============================

# exe_stage_md

Parametrised execute stage for the five-stage in-order pipeline, sitting between decode (ds) and memory (ms). It generalises the single-cycle execute stage in three ways: it adds an iterative multi-cycle divider with a variable-occupancy valid/allowin handshake, sub-word loads and stores with byte enables and alignment checking, and a forwarding/stall interface back to decode. It also accepts a pipeline flush.

## Interface
Parameters:
- XLEN, 32: datapath width; must be 32 or 64.
- DIV_EN, 1: when 0, the divider is not built and div ops complete in 1 cycle with result 0.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- ds_to_es_valid  in  1  decode holds a valid instruction.
- ds_to_es_bus  in  `DS_TO_ES_MD_BUS_WD`  fields, packed MSB to LSB: alu_op[11:0], div_op[1:0] (00 none, 01 div, 10 mod), div_signed, mem_size[1:0] (00 B, 01 H, 10 W, 11 D), load_op, load_unsigned, store_op, src1_is_pc, src2_is_imm, gr_we, dest[4:0], imm, rj_value, rkd_value, pc (each XLEN).
- es_allowin  out  1  stage can accept an instruction this cycle.
- ms_allowin  in  1  memory stage can accept.
- es_to_ms_valid  out  1  result valid toward ms.
- es_to_ms_bus  out  `ES_TO_MS_MD_BUS_WD`  {load_op, load_unsigned, mem_size, addr_lo[2:0], ale, gr_we, dest, result, pc}.
- es_flush  in  1  kill the in-stage instruction.
- es_to_ds_dest  out  5  destination register if valid and gr_we, else 0.
- es_to_ds_load_op  out  1  in-stage op is a valid load.
- es_to_ds_fwd_valid  out  1  es_to_ds_fwd_data is usable this cycle.
- es_to_ds_fwd_data  out  XLEN  result for forwarding.
- data_sram_en  out  1; data_sram_we  out  XLEN/8; data_sram_addr  out  XLEN; data_sram_wdata  out  XLEN.

## Operation
- alu_src1 = src1_is_pc ? pc : rj_value. alu_src2 = src2_is_imm ? imm : rkd_value.
- The ALU is combinational with the existing alu_op encoding. result = div result if div_op != 0, else alu_result.
- Divider: radix-2 restoring algorithm on magnitudes.
  - Signed quotient sign = sign(a) XOR sign(b); remainder takes the sign of the dividend.
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Most-negative / -1: quotient = most-negative, remainder = 0.
- Divider FSM: IDLE -> BUSY on entry of a div op (cnt <= XLEN). BUSY decrements cnt each cycle. BUSY -> DONE when cnt reaches 0. DONE -> IDLE when the instruction leaves the stage or is flushed.
- es_ready_go = (div_op == 0) || state == DONE.
- Addressing: addr = alu_result. ale = (H and addr[0] != 0) || (W and addr[1:0] != 0) || (D and addr[2:0] != 0). mem_size D is legal only when XLEN = 64; otherwise ale = 1.
- Store data is replicated across lanes: B → byte ×XLEN/8, H → half ×XLEN/16, and so on.
- data_sram_we sets the bytes covered by the store at addr's byte offset. It is 0 unless es_valid && store_op && !ale && !es_flush.
- data_sram_en = es_valid && (load_op || store_op) && !ale && !es_flush.
- Forwarding: es_to_ds_fwd_valid = es_valid && gr_we && !load_op && es_ready_go && dest != 0. es_to_ds_fwd_data = result.

## Timing
- Reset values: es_valid 0, divider IDLE, cnt 0, quotient/remainder registers 0. All valid, enable, we and forwarding outputs are 0.
- es_allowin = !es_valid || (es_ready_go && ms_allowin).
- es_to_ms_valid = es_valid && es_ready_go && !es_flush.
- Non-div ops occupy the stage for 1 cycle when ms_allowin = 1.
- Div ops: ready_go rises XLEN+1 cycles after entry. The result is registered and stable while stalled by ms_allowin = 0.
- The bus is latched only when ds_to_es_valid && es_allowin.
- es_flush, at any cycle including mid-division:
  - next cycle: es_valid = 0, FSM IDLE;
  - same cycle: no SRAM access and no es_to_ms_valid.
- If es_flush and ds_to_es_valid are both asserted, the incoming instruction is dropped.
- reset mid-division has the same effect as flush; no residual state.
- A new div may enter in the same cycle the previous one leaves. It restarts the FSM in BUSY with cnt = XLEN.

## Structure
- Shared header mycpu_head.v gains:
  - `DS_TO_ES_MD_BUS_WD`, `ES_TO_MS_MD_BUS_WD`;
  - div_op and mem_size encodings as `define constants.
- Sub-module div_iter (XLEN, ports clk, reset, start, flush, signed_op, a, b, busy, done, quotient, remainder) holds the FSM and counter.
- The existing alu module is instantiated unchanged at XLEN = 32.

## Test plan
- ALU add, with ms_allowin held 1 for 3 back-to-back ops → one es_to_ms_valid per cycle, results correct, fwd_valid each cycle.
- Signed div −7/2 (XLEN = 32) → es_to_ms_valid after 33 cycles with result 0xFFFFFFFD. The same op as mod → 0xFFFFFFFF. es_allowin stays 0 throughout.
- Div by zero on 100 → quotient 0xFFFFFFFF; mod → 100. Div 0x80000000 / −1 signed → 0x80000000.
- Store byte 0xA5 at addr 0x1003 → we = 4'b1000, wdata = 0xA5A5A5A5. Store word at 0x1002 → ale = 1, we = 0, en = 0.
- es_flush asserted at cycle 10 of a div → es_to_ms_valid never rises for it; the next div completes in exactly 33 cycles.
- ms_allowin = 0 for 5 cycles after a div completes → result held stable, es_allowin = 0, and the result passes on the cycle ms_allowin returns to 1.

Source files
------------

// File: rtl/exe_stage_md_pkg.sv
// Shared definitions for the multi-cycle execute stage.
// - div_op / mem_size encodings carried on the decode-to-execute bus
// - one-hot alu_op bit positions
// - divider FSM state type
// - bus width helpers, since both buses scale with XLEN
package exe_stage_md_pkg;

    // div_op encodings
    localparam logic [1:0] DivNone = 2'b00;
    localparam logic [1:0] DivQuot = 2'b01;
    localparam logic [1:0] DivMod  = 2'b10;

    // mem_size encodings
    localparam logic [1:0] MemB = 2'b00;
    localparam logic [1:0] MemH = 2'b01;
    localparam logic [1:0] MemW = 2'b10;
    localparam logic [1:0] MemD = 2'b11;

    // alu_op is one-hot; these are its bit positions
    localparam int unsigned AluAdd  = 0;
    localparam int unsigned AluSub  = 1;
    localparam int unsigned AluSlt  = 2;
    localparam int unsigned AluSltu = 3;
    localparam int unsigned AluAnd  = 4;
    localparam int unsigned AluNor  = 5;
    localparam int unsigned AluOr   = 6;
    localparam int unsigned AluXor  = 7;
    localparam int unsigned AluSll  = 8;
    localparam int unsigned AluSrl  = 9;
    localparam int unsigned AluSra  = 10;
    localparam int unsigned AluLui  = 11;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } div_state_e;

    // alu_op(12) div_op(2) div_signed mem_size(2) load_op load_unsigned store_op
    // src1_is_pc src2_is_imm gr_we dest(5) imm rj_value rkd_value pc
    function automatic int unsigned ds_to_es_bus_wd(input int unsigned xlen);
        return 28 + 4 * xlen;
    endfunction

    // load_op load_unsigned mem_size(2) addr_lo(3) ale gr_we dest(5) result pc
    function automatic int unsigned es_to_ms_bus_wd(input int unsigned xlen);
        return 14 + 2 * xlen;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             load operands and begin (takes priority over flush)
//   flush             abandon / release the current op, return to IDLE
//   signed_op         treat a and b as two's complement
//   a, b              dividend, divisor (sampled on start)
//   busy, done        FSM in BUSY / DONE
//   quotient,remainder registered results, valid while done
// The execute stage also pulses flush when a finished op leaves, which is how
// DONE returns to IDLE; a start in that same cycle restarts straight into BUSY.
module div_iter
    import exe_stage_md_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic            signed_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int unsigned CntW = $clog2(XLEN + 1);

    div_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] part_q, part_d;    // partial remainder magnitude
    logic [XLEN-1:0] shift_q, shift_d;  // dividend bits out, quotient bits in
    logic [XLEN-1:0] dvsr_q, dvsr_d;    // divisor magnitude
    logic [XLEN-1:0] dvnd_q, dvnd_d;    // raw dividend, remainder for divide-by-zero
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            b_zero_q, b_zero_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;

    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   sh;
    logic            ge;
    logic [XLEN-1:0] diff;

    assign a_neg = signed_op & a[XLEN-1];
    assign b_neg = signed_op & b[XLEN-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        part_d   = part_q;
        shift_d  = shift_q;
        dvsr_d   = dvsr_q;
        dvnd_d   = dvnd_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        b_zero_d = b_zero_q;
        quot_d   = quot_q;
        rem_d    = rem_q;

        sh = {part_q, shift_q[XLEN-1]};
        ge = sh >= {1'b0, dvsr_q};
        // When ge the true difference is below the divisor, so the low XLEN bits are exact.
        diff = sh[XLEN-1:0] - dvsr_q;

        if (start) begin
            state_d  = StBusy;
            cnt_d    = CntW'(XLEN);
            part_d   = '0;
            shift_d  = a_mag;
            dvsr_d   = b_mag;
            dvnd_d   = a;
            q_neg_d  = a_neg ^ b_neg;
            r_neg_d  = a_neg;
            b_zero_d = (b == '0);
        end else if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (state_q == StBusy) begin
            if (cnt_q == '0) begin
                state_d = StDone;
                quot_d  = b_zero_q ? '1 : (q_neg_q ? -shift_q : shift_q);
                rem_d   = b_zero_q ? dvnd_q : (r_neg_q ? -part_q : part_q);
            end else begin
                part_d  = ge ? diff : sh[XLEN-1:0];
                shift_d = {shift_q[XLEN-2:0], ge};
                cnt_d   = cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            part_q   <= '0;
            shift_q  <= '0;
            dvsr_q   <= '0;
            dvnd_q   <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            quot_q   <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            part_q   <= part_d;
            shift_q  <= shift_d;
            dvsr_q   <= dvsr_d;
            dvnd_q   <= dvnd_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            b_zero_q <= b_zero_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
        end
    end

    assign busy      = (state_q == StBusy);
    assign done      = (state_q == StDone);
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: rtl/exe_stage_md.sv
// Execute stage between decode and memory: ALU, iterative divider, sub-word
// load/store with alignment check, forwarding/stall info back to decode, flush.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   ds_to_es_valid/ds_to_es_bus      instruction from decode
//   es_allowin                       stage can accept this cycle
//   ms_allowin                       memory stage can accept
//   es_to_ms_valid/es_to_ms_bus      result toward memory stage
//   es_flush                         kill in-stage op and drop any incoming op
//   es_to_ds_dest/load_op/fwd_*      hazard and forwarding info for decode
//   data_sram_*                      data memory request
module exe_stage_md
    import exe_stage_md_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter bit          DIV_EN = 1'b1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               ds_to_es_valid,
    input  logic [ds_to_es_bus_wd(XLEN)-1:0]   ds_to_es_bus,
    output logic                               es_allowin,
    input  logic                               ms_allowin,
    output logic                               es_to_ms_valid,
    output logic [es_to_ms_bus_wd(XLEN)-1:0]   es_to_ms_bus,
    input  logic                               es_flush,
    output logic [4:0]                         es_to_ds_dest,
    output logic                               es_to_ds_load_op,
    output logic                               es_to_ds_fwd_valid,
    output logic [XLEN-1:0]                    es_to_ds_fwd_data,
    output logic                               data_sram_en,
    output logic [XLEN/8-1:0]                  data_sram_we,
    output logic [XLEN-1:0]                    data_sram_addr,
    output logic [XLEN-1:0]                    data_sram_wdata
);

    localparam int unsigned DsWd       = ds_to_es_bus_wd(XLEN);
    localparam int unsigned NumBytes   = XLEN / 8;
    localparam int unsigned OffW       = $clog2(NumBytes);
    localparam int unsigned ShW        = $clog2(XLEN);
    localparam int unsigned PcLsb      = 0;
    localparam int unsigned RkdLsb     = XLEN;
    localparam int unsigned RjLsb      = 2 * XLEN;
    localparam int unsigned ImmLsb     = 3 * XLEN;
    localparam int unsigned DestLsb    = 4 * XLEN;
    localparam int unsigned GrWeBit    = 4 * XLEN + 5;
    localparam int unsigned Src2ImmBit = 4 * XLEN + 6;
    localparam int unsigned Src1PcBit  = 4 * XLEN + 7;
    localparam int unsigned StoreBit   = 4 * XLEN + 8;
    localparam int unsigned LoadUnsBit = 4 * XLEN + 9;
    localparam int unsigned LoadBit    = 4 * XLEN + 10;
    localparam int unsigned MemSizeLsb = 4 * XLEN + 11;
    localparam int unsigned DivSgnBit  = 4 * XLEN + 13;
    localparam int unsigned DivOpLsb   = 4 * XLEN + 14;
    localparam int unsigned AluOpLsb   = 4 * XLEN + 16;

    logic            es_valid_q;
    logic [DsWd-1:0] bus_q;

    // Fields of the in-stage instruction
    logic [11:0]     alu_op;
    logic [1:0]      div_op, mem_size;
    logic            div_signed, load_op, load_unsigned, store_op;
    logic            src1_is_pc, src2_is_imm, gr_we;
    logic [4:0]      dest;
    logic [XLEN-1:0] imm, rj_value, rkd_value, pc;

    assign alu_op        = bus_q[AluOpLsb +: 12];
    assign div_op        = bus_q[DivOpLsb +: 2];
    assign div_signed    = bus_q[DivSgnBit];
    assign mem_size      = bus_q[MemSizeLsb +: 2];
    assign load_op       = bus_q[LoadBit];
    assign load_unsigned = bus_q[LoadUnsBit];
    assign store_op      = bus_q[StoreBit];
    assign src1_is_pc    = bus_q[Src1PcBit];
    assign src2_is_imm   = bus_q[Src2ImmBit];
    assign gr_we         = bus_q[GrWeBit];
    assign dest          = bus_q[DestLsb +: 5];
    assign imm           = bus_q[ImmLsb +: XLEN];
    assign rj_value      = bus_q[RjLsb +: XLEN];
    assign rkd_value     = bus_q[RkdLsb +: XLEN];
    assign pc            = bus_q[PcLsb +: XLEN];

    // The divider must go BUSY on the entry edge, so its operands come straight
    // from the incoming bus rather than from bus_q.
    logic [1:0]      in_div_op;
    logic            in_div_signed;
    logic [XLEN-1:0] in_src1, in_src2;

    assign in_div_op     = ds_to_es_bus[DivOpLsb +: 2];
    assign in_div_signed = ds_to_es_bus[DivSgnBit];
    assign in_src1       = ds_to_es_bus[Src1PcBit] ? ds_to_es_bus[PcLsb +: XLEN]
                                                   : ds_to_es_bus[RjLsb +: XLEN];
    assign in_src2       = ds_to_es_bus[Src2ImmBit] ? ds_to_es_bus[ImmLsb +: XLEN]
                                                    : ds_to_es_bus[RkdLsb +: XLEN];

    logic es_ready_go, es_entry, es_leave, div_start, div_release;
    logic div_busy, div_done;
    logic [XLEN-1:0] div_quot, div_rem, div_result;

    assign es_ready_go    = (div_op == DivNone) || div_done;
    assign es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid_q && es_ready_go && !es_flush;
    assign es_entry       = ds_to_es_valid && es_allowin && !es_flush;
    assign es_leave       = es_valid_q && es_ready_go && ms_allowin;
    assign div_start      = es_entry && (in_div_op != DivNone);
    assign div_release    = es_flush || es_leave;

    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid_q <= 1'b0;
            bus_q      <= '0;
        end else begin
            if (es_flush) begin
                es_valid_q <= 1'b0;
            end else if (es_allowin) begin
                es_valid_q <= ds_to_es_valid;
            end
            if (es_entry) begin
                bus_q <= ds_to_es_bus;
            end
        end
    end

    if (DIV_EN) begin : g_div
        div_iter #(
            .XLEN(XLEN)
        ) u_div_iter (
            .clk       (clk),
            .reset     (reset),
            .start     (div_start),
            .flush     (div_release),
            .signed_op (in_div_signed),
            .a         (in_src1),
            .b         (in_src2),
            .busy      (div_busy),
            .done      (div_done),
            .quotient  (div_quot),
            .remainder (div_rem)
        );
    end else begin : g_no_div
        logic unused_div;
        assign unused_div = ^{div_start, div_release, in_div_signed, in_src1, in_src2};
        assign div_busy   = 1'b0;
        assign div_done   = 1'b1;
        assign div_quot   = '0;
        assign div_rem    = '0;
    end

    assign div_result = div_op[1] ? div_rem : div_quot;

    // ALU
    logic [XLEN-1:0] alu_src1, alu_src2, alu_result;
    logic [ShW-1:0]  shamt;

    assign alu_src1 = src1_is_pc  ? pc  : rj_value;
    assign alu_src2 = src2_is_imm ? imm : rkd_value;
    assign shamt    = alu_src2[ShW-1:0];

    always_comb begin
        alu_result = '0;
        if (alu_op[AluAdd])  alu_result = alu_result | (alu_src1 + alu_src2);
        if (alu_op[AluSub])  alu_result = alu_result | (alu_src1 - alu_src2);
        if (alu_op[AluSlt])  alu_result = alu_result |
            {{(XLEN-1){1'b0}}, $signed(alu_src1) < $signed(alu_src2)};
        if (alu_op[AluSltu]) alu_result = alu_result | {{(XLEN-1){1'b0}}, alu_src1 < alu_src2};
        if (alu_op[AluAnd])  alu_result = alu_result | (alu_src1 & alu_src2);
        if (alu_op[AluNor])  alu_result = alu_result | ~(alu_src1 | alu_src2);
        if (alu_op[AluOr])   alu_result = alu_result | (alu_src1 | alu_src2);
        if (alu_op[AluXor])  alu_result = alu_result | (alu_src1 ^ alu_src2);
        if (alu_op[AluSll])  alu_result = alu_result | (alu_src1 << shamt);
        if (alu_op[AluSrl])  alu_result = alu_result | (alu_src1 >> shamt);
        if (alu_op[AluSra])  alu_result = alu_result | XLEN'($signed(alu_src1) >>> shamt);
        if (alu_op[AluLui])  alu_result = alu_result | alu_src2;
    end

    logic [XLEN-1:0] result;
    assign result = (div_op != DivNone) ? div_result : alu_result;

    // Memory access
    logic [XLEN-1:0]     addr, st_data;
    logic                misalign, ale, mem_ok;
    logic [NumBytes-1:0] size_mask, we_mask;

    assign addr = alu_result;

    always_comb begin
        misalign  = 1'b0;
        size_mask = '1;
        st_data   = rkd_value;
        case (mem_size)
            MemB: begin
                size_mask = NumBytes'(1);
                st_data   = {NumBytes{rkd_value[7:0]}};
            end
            MemH: begin
                misalign  = addr[0];
                size_mask = NumBytes'(3);
                st_data   = {(XLEN/16){rkd_value[15:0]}};
            end
            MemW: begin
                misalign  = |addr[1:0];
                size_mask = NumBytes'(4'hF);
                st_data   = {(XLEN/32){rkd_value[31:0]}};
            end
            default: begin
                // Doubleword exists only on a 64-bit datapath
                misalign = (XLEN == 64) ? |addr[2:0] : 1'b1;
            end
        endcase
    end

    // Only memory ops can raise an alignment error
    assign ale     = (load_op || store_op) && misalign;
    assign we_mask = size_mask << addr[OffW-1:0];
    assign mem_ok  = es_valid_q && !ale && !es_flush;

    assign data_sram_en    = mem_ok && (load_op || store_op);
    assign data_sram_we    = (mem_ok && store_op) ? we_mask : '0;
    assign data_sram_addr  = addr;
    assign data_sram_wdata = st_data;

    assign es_to_ms_bus = {load_op, load_unsigned, mem_size, addr[2:0], ale, gr_we, dest,
                           result, pc};

    // Decode-side hazard and forwarding info
    assign es_to_ds_dest      = (es_valid_q && gr_we) ? dest : 5'd0;
    assign es_to_ds_load_op   = es_valid_q && load_op;
    assign es_to_ds_fwd_valid = es_valid_q && gr_we && !load_op && es_ready_go && (dest != 5'd0);
    assign es_to_ds_fwd_data  = result;

    logic unused_bits;
    assign unused_bits = ^{div_busy, div_signed};

endmodule

// File: tb/tb_exe_stage_md.sv
module tb_exe_stage_md;
    import exe_stage_md_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned DsW  = ds_to_es_bus_wd(XLEN);
    localparam int unsigned MsW  = es_to_ms_bus_wd(XLEN);

    logic           clk, reset;
    logic           ds_to_es_valid, es_allowin, ms_allowin, es_to_ms_valid, es_flush;
    logic [DsW-1:0] ds_to_es_bus;
    logic [MsW-1:0] es_to_ms_bus;
    logic [4:0]     es_to_ds_dest;
    logic           es_to_ds_load_op, es_to_ds_fwd_valid;
    logic [31:0]    es_to_ds_fwd_data;
    logic           data_sram_en;
    logic [3:0]     data_sram_we;
    logic [31:0]    data_sram_addr, data_sram_wdata;

    exe_stage_md #(
        .XLEN   (XLEN),
        .DIV_EN (1'b1)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .ds_to_es_valid     (ds_to_es_valid),
        .ds_to_es_bus       (ds_to_es_bus),
        .es_allowin         (es_allowin),
        .ms_allowin         (ms_allowin),
        .es_to_ms_valid     (es_to_ms_valid),
        .es_to_ms_bus       (es_to_ms_bus),
        .es_flush           (es_flush),
        .es_to_ds_dest      (es_to_ds_dest),
        .es_to_ds_load_op   (es_to_ds_load_op),
        .es_to_ds_fwd_valid (es_to_ds_fwd_valid),
        .es_to_ds_fwd_data  (es_to_ds_fwd_data),
        .data_sram_en       (data_sram_en),
        .data_sram_we       (data_sram_we),
        .data_sram_addr     (data_sram_addr),
        .data_sram_wdata    (data_sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ms_result;
    logic        ms_ale;
    assign ms_result = es_to_ms_bus[63:32];
    assign ms_ale    = es_to_ms_bus[70];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DsW-1:0] mk(input logic [11:0] aop, input logic [1:0] dop,
                                          input logic sgn, input logic [1:0] msz,
                                          input logic ld, input logic st, input logic s2i,
                                          input logic gwe, input logic [4:0] dst,
                                          input logic [31:0] imm, input logic [31:0] rj,
                                          input logic [31:0] rkd);
        return {aop, dop, sgn, msz, ld, 1'b0, st, 1'b0, s2i, gwe, dst, imm, rj, rkd,
                32'h1c00_0000};
    endfunction

    // Issue a div at the current negedge and follow it to completion.
    task automatic div_run(input string tag, input logic [1:0] dop, input logic sgn,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        int cyc = 0;
        int bad = 0;
        ds_to_es_bus   = mk(12'h000, dop, sgn, MemW, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h0, a, b);
        ds_to_es_valid = 1'b1;
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        while (cyc < 100 && !es_to_ms_valid) begin
            if (es_allowin) bad++;
            cyc++;
            @(negedge clk);
        end
        check({tag, "_lat"}, 64'(cyc), 64'd33);
        check({tag, "_res"}, 64'(ms_result), 64'(exp));
        check({tag, "_stall"}, 64'(bad), 64'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          bad;
        int          rose;
        int          cyc;
        logic [31:0] held;

        reset          = 1'b1;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = '0;
        ms_allowin     = 1'b1;
        es_flush       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ms_valid", 64'(es_to_ms_valid), 64'd0);
        check("rst_allowin", 64'(es_allowin), 64'd1);
        check("rst_sram_en", 64'(data_sram_en), 64'd0);
        check("rst_sram_we", 64'(data_sram_we), 64'd0);
        check("rst_fwd_valid", 64'(es_to_ds_fwd_valid), 64'd0);
        check("rst_dest", 64'(es_to_ds_dest), 64'd0);
        reset = 1'b0;

        // Three back-to-back adds
        ds_to_es_bus = mk(12'h001, DivNone, 0, MemW, 0, 0, 0, 1, 5'd3, 32'h0, 32'd5, 32'd7);
        ds_to_es_valid = 1'b1;
        @(negedge clk);
        check("add0_valid", 64'(es_to_ms_valid), 64'd1);
        check("add0_res", 64'(ms_result), 64'd12);
        check("add0_fwd", 64'(es_to_ds_fwd_valid), 64'd1);
        check("add0_fwd_data", 64'(es_to_ds_fwd_data), 64'd12);
        ds_to_es_bus = mk(12'h001, DivNone, 0, MemW, 0, 0, 0, 1, 5'd5, 32'h0, 32'hFFFF_FFFF,
                          32'd2);
        @(negedge clk);
        check("add1_valid", 64'(es_to_ms_valid), 64'd1);
        check("add1_res", 64'(ms_result), 64'd1);
        check("add1_fwd", 64'(es_to_ds_fwd_valid), 64'd1);
        ds_to_es_bus = mk(12'h001, DivNone, 0, MemW, 0, 0, 1, 1, 5'd7, 32'h100, 32'h23,
                          32'hDEAD);
        @(negedge clk);
        check("add2_valid", 64'(es_to_ms_valid), 64'd1);
        check("add2_res", 64'(ms_result), 64'h123);
        check("add2_dest", 64'(es_to_ds_dest), 64'd7);
        ds_to_es_valid = 1'b0;
        @(negedge clk);
        check("add_drain", 64'(es_to_ms_valid), 64'd0);

        // Divider, chained so each new div enters as the previous leaves
        div_run("sdiv", DivQuot, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        div_run("smod", DivMod, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        div_run("div0", DivQuot, 1'b0, 32'd100, 32'd0, 32'hFFFF_FFFF);
        div_run("mod0", DivMod, 1'b0, 32'd100, 32'd0, 32'd100);
        div_run("ovf_q", DivQuot, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        div_run("ovf_r", DivMod, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

        // Stores and loads
        ds_to_es_bus = mk(12'h001, DivNone, 0, MemB, 0, 1, 1, 0, 5'd0, 32'h3, 32'h1000,
                          32'h0000_00A5);
        ds_to_es_valid = 1'b1;
        @(negedge clk);
        check("stb_en", 64'(data_sram_en), 64'd1);
        check("stb_we", 64'(data_sram_we), 64'b1000);
        check("stb_wdata", 64'(data_sram_wdata), 64'hA5A5_A5A5);
        check("stb_addr", 64'(data_sram_addr), 64'h1003);
        check("stb_ale", 64'(ms_ale), 64'd0);
        ds_to_es_bus = mk(12'h001, DivNone, 0, MemW, 0, 1, 1, 0, 5'd0, 32'h2, 32'h1000,
                          32'h1234_5678);
        @(negedge clk);
        check("stw_ale", 64'(ms_ale), 64'd1);
        check("stw_we", 64'(data_sram_we), 64'd0);
        check("stw_en", 64'(data_sram_en), 64'd0);
        ds_to_es_bus = mk(12'h001, DivNone, 0, MemH, 0, 1, 1, 0, 5'd0, 32'h2, 32'h1000,
                          32'h0000_BEEF);
        @(negedge clk);
        check("sth_we", 64'(data_sram_we), 64'b1100);
        check("sth_wdata", 64'(data_sram_wdata), 64'hBEEF_BEEF);
        ds_to_es_bus = mk(12'h001, DivNone, 0, MemW, 1, 0, 1, 1, 5'd9, 32'h4, 32'h1000,
                          32'h0);
        @(negedge clk);
        check("ldw_en", 64'(data_sram_en), 64'd1);
        check("ldw_we", 64'(data_sram_we), 64'd0);
        check("ldw_load_op", 64'(es_to_ds_load_op), 64'd1);
        check("ldw_fwd", 64'(es_to_ds_fwd_valid), 64'd0);
        check("ldw_dest", 64'(es_to_ds_dest), 64'd9);
        ds_to_es_bus = mk(12'h001, DivNone, 0, MemB, 0, 1, 1, 0, 5'd0, 32'h1, 32'h1000,
                          32'h0000_0011);
        @(negedge clk);
        // Flush the store in stage while an add arrives: both must vanish
        es_flush     = 1'b1;
        ds_to_es_bus = mk(12'h001, DivNone, 0, MemW, 0, 0, 0, 1, 5'd6, 32'h0, 32'd1, 32'd1);
        #1;
        check("flush_st_en", 64'(data_sram_en), 64'd0);
        check("flush_st_we", 64'(data_sram_we), 64'd0);
        check("flush_st_valid", 64'(es_to_ms_valid), 64'd0);
        @(negedge clk);
        es_flush       = 1'b0;
        ds_to_es_valid = 1'b0;
        check("flush_drop_valid", 64'(es_to_ms_valid), 64'd0);
        check("flush_drop_allowin", 64'(es_allowin), 64'd1);

        // Flush at cycle 10 of a division
        ds_to_es_bus = mk(12'h000, DivQuot, 0, MemW, 0, 0, 0, 1, 5'd4, 32'h0, 32'd1000, 32'd7);
        ds_to_es_valid = 1'b1;
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        rose = 0;
        repeat (10) begin
            if (es_to_ms_valid) rose++;
            @(negedge clk);
        end
        check("mid_div_fwd", 64'(es_to_ds_fwd_valid), 64'd0);
        check("mid_div_dest", 64'(es_to_ds_dest), 64'd4);
        es_flush = 1'b1;
        #1;
        if (es_to_ms_valid) rose++;
        @(negedge clk);
        es_flush = 1'b0;
        check("div_flush_allowin", 64'(es_allowin), 64'd1);
        repeat (40) begin
            if (es_to_ms_valid) rose++;
            @(negedge clk);
        end
        check("div_flush_norise", 64'(rose), 64'd0);
        div_run("post_flush", DivQuot, 1'b0, 32'd1000, 32'd7, 32'd142);

        // Reset in the middle of a division
        ds_to_es_bus = mk(12'h000, DivQuot, 0, MemW, 0, 0, 0, 1, 5'd4, 32'h0, 32'd1000, 32'd7);
        ds_to_es_valid = 1'b1;
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("div_rst_allowin", 64'(es_allowin), 64'd1);
        check("div_rst_valid", 64'(es_to_ms_valid), 64'd0);
        div_run("post_rst", DivMod, 1'b0, 32'd1000, 32'd7, 32'd6);

        // Memory stage back-pressure after a division completes
        @(negedge clk);
        ms_allowin     = 1'b0;
        ds_to_es_bus   = mk(12'h000, DivQuot, 0, MemW, 0, 0, 0, 1, 5'd4, 32'h0, 32'd1000,
                            32'd7);
        ds_to_es_valid = 1'b1;
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        cyc = 0;
        while (cyc < 100 && !es_to_ms_valid) begin
            cyc++;
            @(negedge clk);
        end
        check("hold_lat", 64'(cyc), 64'd33);
        held = 32'd142;
        bad  = 0;
        repeat (5) begin
            if (ms_result !== held || es_allowin || !es_to_ms_valid) bad++;
            @(negedge clk);
        end
        check("hold_stable", 64'(bad), 64'd0);
        ms_allowin = 1'b1;
        #1;
        check("hold_release_allowin", 64'(es_allowin), 64'd1);
        check("hold_release_valid", 64'(es_to_ms_valid), 64'd1);
        check("hold_release_res", 64'(ms_result), 64'd142);
        @(negedge clk);
        check("hold_left", 64'(es_to_ms_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
